// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: gfedcba glyph table, slot FSM states, polarity-aware lookup.
// Pure constants and functions; no latency, no flow control.
package seven_seg_pkg;

   typedef enum logic {
      DEAD = 1'b0,
      SHOW = 1'b1
   } fsm_state_t;

   // Active-low gfedcba patterns for hex 0..F (b and d are lower case).
   localparam logic [6:0] SEG_LUT [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   function automatic logic [6:0] to_seg(input logic [3:0] nibble, input logic active_low);
      logic [6:0] pat;
      pat = SEG_LUT[nibble];
      return active_low ? pat : ~pat;
   endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Hex nibble to seven-segment pattern for the selected polarity.
// Combinational, zero latency; no flow control.
module seven_seg_decoder
   import seven_seg_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = to_seg(nibble_i, ACTIVE_LOW);
   end

endmodule

// File: rtl/seven_seg_mux_n.sv
// N-digit time-multiplexed seven-segment driver with per-frame snapshot, dead time, blanking and LZ suppression.
// All outputs registered; display changes take effect one cycle after the edge that computes them; no backpressure.
module seven_seg_mux_n
   import seven_seg_pkg::*;
#(
   parameter int  NUM_DIGITS     = 4,
   parameter int  REFRESH_DIV    = 24000,
   parameter int  DEAD_CYCLES    = 240,
   parameter bit  SEG_ACTIVE_LOW = 1'b1,
   parameter bit  EN_ACTIVE_LOW  = 1'b1,
   localparam int SUM_W          = $clog2(15*NUM_DIGITS+1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] digits_i,
   input  logic [NUM_DIGITS-1:0]   blank_mask_i,
   input  logic                    lz_suppress_i,
   output logic [6:0]              seg_o,
   output logic [NUM_DIGITS-1:0]   en_o,
   output logic [SUM_W-1:0]        sum_o,
   output logic                    frame_tick_o
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = $clog2(NUM_DIGITS);

   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0]      DEAD_END = CNT_W'(DEAD_CYCLES);
   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [6:0]            SEG_OFF  = {7{SEG_ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] EN_OFF   = {NUM_DIGITS{EN_ACTIVE_LOW}};

   logic                    run_q, run_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] snap_dig_q, snap_dig_d;
   logic [NUM_DIGITS-1:0]   snap_mask_q, snap_mask_d;
   logic                    snap_lz_q, snap_lz_d;
   fsm_state_t              state_q, state_d;
   logic [6:0]              seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   en_q, en_d;
   logic [SUM_W-1:0]        sum_q, sum_d;
   logic                    tick_q, tick_d;

   logic                    frame_start;
   logic [SUM_W-1:0]        sum_calc;
   logic [NUM_DIGITS-1:0]   dark;
   logic                    zero_above;
   logic [3:0]              nib_sel;
   logic [6:0]              dec_seg;
   logic [NUM_DIGITS-1:0]   onehot;

   // Slot counter and digit index; the first edge out of reset opens frame 0.
   always_comb begin
      run_d       = 1'b1;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      frame_start = 1'b0;
      if (!run_q) begin
         cnt_d       = '0;
         idx_d       = '0;
         frame_start = 1'b1;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         if (idx_q == IDX_LAST) begin
            idx_d       = '0;
            frame_start = 1'b1;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_comb begin
      sum_calc = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         sum_calc = sum_calc + SUM_W'(digits_i[4*k +: 4]);
      end
      snap_dig_d  = frame_start ? digits_i      : snap_dig_q;
      snap_mask_d = frame_start ? blank_mask_i  : snap_mask_q;
      snap_lz_d   = frame_start ? lz_suppress_i : snap_lz_q;
      sum_d       = frame_start ? sum_calc      : sum_q;
      tick_d      = frame_start;
   end

   // Dark map is derived from the snapshot that will be live next cycle, so a new frame shows new data at once.
   always_comb begin
      zero_above = 1'b1;
      dark       = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         dark[k]    = snap_mask_d[k] |
                      (snap_lz_d & zero_above & (snap_dig_d[4*k +: 4] == 4'h0) & (k != 0));
         zero_above = zero_above & (snap_dig_d[4*k +: 4] == 4'h0);
      end
   end

   always_comb begin
      nib_sel = snap_dig_d[4*idx_d +: 4];
   end

   seven_seg_decoder #(
      .ACTIVE_LOW (SEG_ACTIVE_LOW)
   ) u_dec (
      .nibble_i (nib_sel),
      .seg_o    (dec_seg)
   );

   always_comb begin
      if (cnt_d == '0) begin
         state_d = (DEAD_END != '0) ? DEAD : SHOW;
      end else if (cnt_d == DEAD_END) begin
         state_d = SHOW;
      end else begin
         state_d = state_q;
      end

      onehot = NUM_DIGITS'(1) << idx_d;
      seg_d  = SEG_OFF;
      en_d   = EN_OFF;
      if (state_d == SHOW && !dark[idx_d]) begin
         seg_d = dec_seg;
         en_d  = onehot ^ EN_OFF;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         run_q       <= 1'b0;
         cnt_q       <= '0;
         idx_q       <= '0;
         snap_dig_q  <= '0;
         snap_mask_q <= '0;
         snap_lz_q   <= 1'b0;
         state_q     <= DEAD;
         seg_q       <= SEG_OFF;
         en_q        <= EN_OFF;
         sum_q       <= '0;
         tick_q      <= 1'b0;
      end else begin
         run_q       <= run_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         snap_dig_q  <= snap_dig_d;
         snap_mask_q <= snap_mask_d;
         snap_lz_q   <= snap_lz_d;
         state_q     <= state_d;
         seg_q       <= seg_d;
         en_q        <= en_d;
         sum_q       <= sum_d;
         tick_q      <= tick_d;
      end
   end

   assign seg_o        = seg_q;
   assign en_o         = en_q;
   assign sum_o        = sum_q;
   assign frame_tick_o = tick_q;

endmodule

// File: tb/tb_seven_seg_mux_n.sv
// Bench for seven_seg_mux_n: 4 digits, 8-cycle slots, 2 dead cycles, active-low segments and enables.
`timescale 1ns/1ps
module tb_seven_seg_mux_n;

   localparam int ND = 4;
   localparam int RD = 8;
   localparam int DC = 2;
   localparam int FRAME = ND * RD;

   localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
   localparam logic [6:0] G4 = 7'b0011001, G5 = 7'b0010010, G6 = 7'b0000010, G7 = 7'b1111000;
   localparam logic [6:0] G8 = 7'b0000000, G9 = 7'b0010000, GA = 7'b0001000, GB = 7'b0000011;
   localparam logic [6:0] GC = 7'b1000110, GD = 7'b0100001, GE = 7'b0000110, GF = 7'b0001110;
   localparam logic [6:0] OFF = 7'b1111111;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] digits_i;
   logic [3:0]  blank_mask_i;
   logic        lz_suppress_i;
   logic [6:0]  seg_o;
   logic [3:0]  en_o;
   logic [5:0]  sum_o;
   logic        frame_tick_o;

   always #5 clk = ~clk;

   seven_seg_mux_n #(
      .NUM_DIGITS     (ND),
      .REFRESH_DIV    (RD),
      .DEAD_CYCLES    (DC),
      .SEG_ACTIVE_LOW (1'b1),
      .EN_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .digits_i      (digits_i),
      .blank_mask_i  (blank_mask_i),
      .lz_suppress_i (lz_suppress_i),
      .seg_o         (seg_o),
      .en_o          (en_o),
      .sum_o         (sum_o),
      .frame_tick_o  (frame_tick_o)
   );

   // One frame of stimulus with the hand-derived display it must produce; seg[k] is digit k.
   typedef struct {
      logic [15:0]     digits;
      logic [3:0]      mask;
      logic            lz;
      logic [5:0]      sum;
      logic [3:0]      lit;
      logic [3:0][6:0] seg;
   } vec_t;

   typedef struct {
      logic [3:0] en;
      logic [6:0] seg;
      logic [5:0] sum;
      logic       tick;
   } exp_t;

   vec_t vecs [9];
   exp_t sb [$];
   exp_t rst_exp;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic apply(input int vi);
      digits_i      = vecs[vi].digits;
      blank_mask_i  = vecs[vi].mask;
      lz_suppress_i = vecs[vi].lz;
   endtask

   function automatic exp_t frame_exp(input vec_t v, input int cyc);
      exp_t e;
      int   s = cyc / RD;
      int   c = cyc % RD;
      e.sum  = v.sum;
      e.tick = (cyc == 0);
      e.en   = 4'hF;
      e.seg  = OFF;
      if (c >= DC && v.lit[s]) begin
         e.en  = ~(4'b0001 << s);
         e.seg = v.seg[s];
      end
      return e;
   endfunction

   task automatic step(input exp_t e, input string tag);
      exp_t x;
      sb.push_back(e);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      n_tests++;
      if (en_o !== x.en || seg_o !== x.seg || sum_o !== x.sum || frame_tick_o !== x.tick) begin
         n_fail++;
         $display("FAIL %s: got en=%b seg=%b sum=%0d tick=%b, want en=%b seg=%b sum=%0d tick=%b",
                  tag, en_o, seg_o, sum_o, frame_tick_o, x.en, x.seg, x.sum, x.tick);
      end
   endtask

   // Runs cycles 0..ncyc-1 of a frame; scribbles junk early and loads the next vector mid-frame,
   // neither of which may show before the next frame start.
   task automatic run_frame(input int vi, input int ncyc, input int nxt);
      for (int c = 0; c < ncyc; c++) begin
         step(frame_exp(vecs[vi], c), $sformatf("v%0d_c%0d", vi, c));
         if (c == 4) begin
            digits_i      = 16'($urandom);
            blank_mask_i  = 4'($urandom);
            lz_suppress_i = 1'($urandom);
         end
         if (c == 12) apply(nxt);
      end
   endtask

   initial begin
      vecs[0] = '{16'h1234, 4'b0000, 1'b0, 6'd10, 4'b1111, {G1, G2, G3, G4}};
      vecs[1] = '{16'hFFFF, 4'b0000, 1'b0, 6'd60, 4'b1111, {GF, GF, GF, GF}};
      vecs[2] = '{16'h0070, 4'b0000, 1'b1, 6'd7,  4'b0011, {OFF, OFF, G7, G0}};
      vecs[3] = '{16'h0000, 4'b0000, 1'b1, 6'd0,  4'b0001, {OFF, OFF, OFF, G0}};
      vecs[4] = '{16'h8888, 4'b0100, 1'b0, 6'd32, 4'b1011, {G8, OFF, G8, G8}};
      vecs[5] = '{16'h0070, 4'b0000, 1'b0, 6'd7,  4'b1111, {G0, G0, G7, G0}};
      vecs[6] = '{16'h0A0B, 4'b0000, 1'b1, 6'd21, 4'b0111, {OFF, GA, G0, GB}};
      vecs[7] = '{16'hCDE0, 4'b0001, 1'b1, 6'd39, 4'b1110, {GC, GD, GE, OFF}};
      vecs[8] = '{16'h5690, 4'b0000, 1'b0, 6'd20, 4'b1111, {G5, G6, G9, G0}};
      rst_exp = '{4'hF, OFF, 6'd0, 1'b0};

      reset = 1'b1;
      apply(0);
      for (int i = 0; i < 3; i++) step(rst_exp, $sformatf("reset_%0d", i));

      reset = 1'b0;
      for (int v = 0; v < 9; v++) run_frame(v, FRAME, (v < 8) ? v + 1 : 0);

      // Reset lands during cycle 5 of slot 2, then a fresh frame must start at digit 0.
      run_frame(0, 2 * RD + 6, 0);
      reset = 1'b1;
      step(rst_exp, "mid_reset_0");
      step(rst_exp, "mid_reset_1");
      apply(8);
      reset = 1'b0;
      run_frame(8, FRAME, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
